// File: rtl/imager_pkg.sv
// Shared definitions for the imager mask path: geometry, sequencer states
// and the subscene phase codes seen by the pattern generator and row driver.
package imager_pkg;

    localparam int C_NUM_ROWS       = 160;
    localparam int C_WORDS_PER_ROW  = 18;
    localparam int C_WORDS_PER_SUBC = C_NUM_ROWS * C_WORDS_PER_ROW;
    localparam int C_RST_CYCLES     = 2;

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_RST   = 6'b000010,
        S_FIRST = 6'b000100,
        S_PATS  = 6'b001000,
        S_LAST  = 6'b010000,
        S_DONE  = 6'b100000
    } seq_state_t;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_FIRST = 2'd1,
        PH_PATS  = 2'd2,
        PH_LAST  = 2'd3
    } subc_phase_t;

    // A host value of zero exposed patterns still runs one exposed subscene.
    function automatic logic [31:0] eff_num_pat(input logic [31:0] num_pat);
        return (num_pat == 32'd0) ? 32'd1 : num_pat;
    endfunction

endpackage

// File: rtl/subc_word_counter.sv
// Modulo-C_MOD word counter with enable, synchronous clear (priority over
// enable) and a terminal-count flag used to find subscene boundaries.
module subc_word_counter #(
    parameter int C_MOD = 2880,
    localparam int W = (C_MOD > 1) ? $clog2(C_MOD) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = (count == W'(C_MOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (tc) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/subc_sequencer.sv
// Frame-level scheduler: parks the pattern generator in reset until a run
// starts, then drains the pattern FIFO and counts words, subscenes and frames.
module subc_sequencer
    import imager_pkg::*;
#(
    parameter int C_NUM_ROWS       = imager_pkg::C_NUM_ROWS,
    parameter int C_WORDS_PER_ROW  = imager_pkg::C_WORDS_PER_ROW,
    parameter int C_WORDS_PER_SUBC = C_NUM_ROWS * C_WORDS_PER_ROW,
    parameter int C_RST_CYCLES     = imager_pkg::C_RST_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] Num_Pat,
    input  logic [15:0] Num_Frames,
    input  logic        FIFO_empty,
    input  logic        Row_ready,
    output logic        FIFO_rd,
    output logic        Pat_valid,
    output logic        PatGen_rst,
    output logic [31:0] CntSubc,
    output logic [15:0] Frame_cnt,
    output logic [1:0]  Subc_phase,
    output logic        Busy,
    output logic        Done,
    output logic        Underrun
);

    localparam int CNT_W = (C_WORDS_PER_SUBC > 1) ? $clog2(C_WORDS_PER_SUBC) : 1;
    localparam int RST_W = (C_RST_CYCLES > 1) ? $clog2(C_RST_CYCLES + 1) : 1;

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [RST_W-1:0] rst_cnt;
    logic [CNT_W-1:0] word_cnt;
    logic             word_tc;
    logic             rd_phase;
    logic             subc_end;
    logic             rst_done;
    logic             aborting;
    logic [31:0]      cnt_subc_inc;
    logic [15:0]      frame_inc;
    logic             cnt_subc_step;
    logic             cnt_subc_clr;
    logic             frame_step;
    logic             run_clr;

    assign rd_phase     = (state == S_FIRST) || (state == S_PATS) || (state == S_LAST);
    assign FIFO_rd      = Row_ready & ~FIFO_empty & rd_phase;
    assign subc_end     = FIFO_rd & word_tc;
    assign rst_done     = (rst_cnt == RST_W'(C_RST_CYCLES - 1));
    assign aborting     = abort && (state != S_IDLE);
    assign cnt_subc_inc = CntSubc + 32'd1;
    assign frame_inc    = Frame_cnt + 16'd1;

    subc_word_counter #(
        .C_MOD (C_WORDS_PER_SUBC)
    ) u_word_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (FIFO_rd),
        .clr   (run_clr | aborting),
        .count (word_cnt),
        .tc    (word_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            PatGen_rst <= 1'b1;
            Pat_valid  <= 1'b0;
        end else begin
            state      <= state_nxt;
            PatGen_rst <= (state_nxt == S_IDLE) || (state_nxt == S_RST);
            Pat_valid  <= FIFO_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_cnt <= '0;
        end else if (state == S_RST) begin
            rst_cnt <= rst_cnt + 1'b1;
        end else begin
            rst_cnt <= '0;
        end
    end

    // Abort suppresses the counter strobes, so an aborted run leaves its counts visible.
    always_comb begin
        state_nxt     = state;
        cnt_subc_step = 1'b0;
        cnt_subc_clr  = 1'b0;
        frame_step    = 1'b0;
        run_clr       = 1'b0;
        Busy          = (state != S_IDLE);
        Done          = (state == S_DONE);
        Subc_phase    = PH_IDLE;

        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    run_clr   = 1'b1;
                    state_nxt = S_RST;
                end
            end
            S_RST: begin
                if (rst_done) state_nxt = S_FIRST;
            end
            S_FIRST: begin
                Subc_phase = PH_FIRST;
                if (subc_end) state_nxt = S_PATS;
            end
            S_PATS: begin
                Subc_phase = PH_PATS;
                if (subc_end) begin
                    cnt_subc_step = 1'b1;
                    if (cnt_subc_inc == eff_num_pat(Num_Pat)) state_nxt = S_LAST;
                end
            end
            S_LAST: begin
                Subc_phase = PH_LAST;
                if (subc_end) begin
                    frame_step = 1'b1;
                    if ((Num_Frames != 16'd0) && (frame_inc == Num_Frames)) begin
                        state_nxt = S_DONE;
                    end else begin
                        cnt_subc_clr = 1'b1;
                        state_nxt    = S_FIRST;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (aborting) begin
            state_nxt     = S_IDLE;
            cnt_subc_step = 1'b0;
            cnt_subc_clr  = 1'b0;
            frame_step    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            CntSubc   <= '0;
            Frame_cnt <= '0;
            Underrun  <= 1'b0;
        end else if (run_clr) begin
            CntSubc   <= '0;
            Frame_cnt <= '0;
            Underrun  <= 1'b0;
        end else begin
            if (cnt_subc_clr) begin
                CntSubc <= '0;
            end else if (cnt_subc_step) begin
                CntSubc <= cnt_subc_inc;
            end
            if (frame_step) begin
                Frame_cnt <= frame_inc;
            end
            if ((state == S_PATS) && Row_ready && FIFO_empty && (word_cnt != '0)) begin
                Underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_subc_sequencer.sv
// Directed self-checking bench for subc_sequencer with 8-word subscenes.
module tb_subc_sequencer;

    localparam int WPS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] Num_Pat = '0;
    logic [15:0] Num_Frames = '0;
    logic        FIFO_empty = 1'b0;
    logic        Row_ready = 1'b0;
    logic        FIFO_rd;
    logic        Pat_valid;
    logic        PatGen_rst;
    logic [31:0] CntSubc;
    logic [15:0] Frame_cnt;
    logic [1:0]  Subc_phase;
    logic        Busy;
    logic        Done;
    logic        Underrun;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    subc_sequencer #(
        .C_WORDS_PER_SUBC (WPS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .Num_Pat    (Num_Pat),
        .Num_Frames (Num_Frames),
        .FIFO_empty (FIFO_empty),
        .Row_ready  (Row_ready),
        .FIFO_rd    (FIFO_rd),
        .Pat_valid  (Pat_valid),
        .PatGen_rst (PatGen_rst),
        .CntSubc    (CntSubc),
        .Frame_cnt  (Frame_cnt),
        .Subc_phase (Subc_phase),
        .Busy       (Busy),
        .Done       (Done),
        .Underrun   (Underrun)
    );

    task automatic kick(input int np, input int nf);
        @(posedge clk); #1;
        Num_Pat    = 32'(np);
        Num_Frames = 16'(nf);
        Row_ready  = 1'b1;
        FIFO_empty = 1'b0;
        start      = 1'b1;
    endtask

    task automatic advance_reads(input int target, inout int r, input string tag);
        for (int g = 0; g < 300 && r < target; g++) begin
            @(posedge clk); #1;
            start     = 1'b0;
            Row_ready = 1'b1;
            @(negedge clk);
            if (FIFO_rd === 1'b1) r++;
        end
        vectors++;
        if (r != target) begin
            miscompares++;
            $display("[TB] FAIL %s_timeout: got %0d reads expected %0d", tag, r, target);
        end
    endtask

    // Full run with an independent model of counters/phase derived from the read count.
    task automatic run_scenario(input int np, input int nf, input int stall_at,
                                input int stall_len, input string tag);
        int np_eff, p, total, r, stalled, k, exp_cnt, exp_ph;
        logic prev_rd;
        bit done_seen;
        np_eff = (np == 0) ? 1 : np;
        p      = np_eff + 2;
        total  = nf * p * WPS;
        kick(np, nf);
        @(negedge clk);
        vectors++;
        if (Busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s_busy_start_cycle: got %b expected 0", tag, Busy);
        end
        r = 0; stalled = 0; prev_rd = 1'b0; done_seen = 1'b0;
        for (int cyc = 1; cyc <= total + stall_len + 10 && !done_seen; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (r == stall_at && stalled < stall_len) begin
                Row_ready = 1'b0;
                stalled++;
            end else begin
                Row_ready = 1'b1;
            end
            @(negedge clk);
            if (cyc == 1) begin
                vectors++;
                if ({Busy, PatGen_rst} !== 2'b11) begin
                    miscompares++;
                    $display("[TB] FAIL %s_t1: got Busy,PatGen_rst=%b%b expected 11", tag, Busy, PatGen_rst);
                end
            end
            if (cyc == 3) begin
                vectors++;
                if ({PatGen_rst, FIFO_rd} !== 2'b01) begin
                    miscompares++;
                    $display("[TB] FAIL %s_first_read: got PatGen_rst,FIFO_rd=%b%b expected 01", tag, PatGen_rst, FIFO_rd);
                end
            end
            if (cyc >= 2) begin
                vectors++;
                if (Pat_valid !== prev_rd) begin
                    miscompares++;
                    $display("[TB] FAIL %s_pat_valid: got %b expected %b (cycle %0d)", tag, Pat_valid, prev_rd, cyc);
                end
            end
            if (Done === 1'b1) begin
                done_seen = 1'b1;
                vectors += 4;
                if (r != total) begin
                    miscompares++;
                    $display("[TB] FAIL %s_total_reads: got %0d expected %0d", tag, r, total);
                end
                if (cyc != 3 + total + stall_len) begin
                    miscompares++;
                    $display("[TB] FAIL %s_done_cycle: got %0d expected %0d", tag, cyc, 3 + total + stall_len);
                end
                if (Frame_cnt !== 16'(nf)) begin
                    miscompares++;
                    $display("[TB] FAIL %s_final_frames: got %0d expected %0d", tag, Frame_cnt, nf);
                end
                if (CntSubc !== 32'(np_eff)) begin
                    miscompares++;
                    $display("[TB] FAIL %s_final_cntsubc: got %0d expected %0d", tag, CntSubc, np_eff);
                end
            end else if (cyc >= 3) begin
                k       = (r / WPS) % p;
                exp_cnt = (k == 0) ? 0 : k - 1;
                exp_ph  = (k == 0) ? 1 : ((k == p - 1) ? 3 : 2);
                vectors += 3;
                if (CntSubc !== 32'(exp_cnt)) begin
                    miscompares++;
                    $display("[TB] FAIL %s_cntsubc: got %0d expected %0d (reads %0d)", tag, CntSubc, exp_cnt, r);
                end
                if (Frame_cnt !== 16'(r / (WPS * p))) begin
                    miscompares++;
                    $display("[TB] FAIL %s_frame_cnt: got %0d expected %0d (reads %0d)", tag, Frame_cnt, r / (WPS * p), r);
                end
                if (Subc_phase !== 2'(exp_ph)) begin
                    miscompares++;
                    $display("[TB] FAIL %s_phase: got %0d expected %0d (reads %0d)", tag, Subc_phase, exp_ph, r);
                end
            end
            if (Row_ready === 1'b0) begin
                vectors++;
                if (FIFO_rd !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL %s_stall_read: got %b expected 0", tag, FIFO_rd);
                end
            end
            prev_rd = FIFO_rd;
            if (FIFO_rd === 1'b1) r++;
        end
        vectors++;
        if (!done_seen) begin
            miscompares++;
            $display("[TB] FAIL %s_done_timeout: got no Done expected Done after %0d reads", tag, total);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if ({Busy, Done, PatGen_rst} !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL %s_after_done: got Busy,Done,PatGen_rst=%b%b%b expected 001", tag, Busy, Done, PatGen_rst);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        Row_ready = 1'b1;
        #12;
        vectors += 3;
        if ({PatGen_rst, FIFO_rd, Pat_valid, Busy, Done, Underrun} !== 6'b100000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b expected 100000", {PatGen_rst, FIFO_rd, Pat_valid, Busy, Done, Underrun});
        end
        if ({CntSubc, Frame_cnt} !== 48'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_counts: got %0d/%0d expected 0/0", CntSubc, Frame_cnt);
        end
        if (Subc_phase !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_phase: got %0d expected 0", Subc_phase);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({PatGen_rst, Busy, FIFO_rd} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL idle_after_reset: got %b expected 100", {PatGen_rst, Busy, FIFO_rd});
        end
    endtask

    task automatic test_full_run;
        run_scenario(3, 2, -1, 0, "full_run");
    endtask

    task automatic test_num_pat_zero;
        run_scenario(0, 1, -1, 0, "num_pat_zero");
    endtask

    task automatic test_stall;
        run_scenario(2, 1, 19, 5, "stall");
    endtask

    task automatic test_underrun;
        int r;
        r = 0;
        kick(3, 1);
        advance_reads(11, r, "underrun_lead");
        vectors++;
        if (Underrun !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL underrun_pre: got %b expected 0", Underrun);
        end
        @(posedge clk); #1;
        FIFO_empty = 1'b1;
        @(negedge clk);
        vectors += 2;
        if (FIFO_rd !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL underrun_no_read: got %b expected 0", FIFO_rd);
        end
        if (Subc_phase !== 2'd2) begin
            miscompares++;
            $display("[TB] FAIL underrun_phase: got %0d expected 2", Subc_phase);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (Underrun !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL underrun_set: got %b expected 1", Underrun);
        end
        @(posedge clk); #1;
        FIFO_empty = 1'b0;
        @(negedge clk);
        vectors++;
        if ({FIFO_rd, Underrun} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL underrun_resume: got FIFO_rd,Underrun=%b%b expected 11", FIFO_rd, Underrun);
        end
        repeat (10) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (Underrun !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL underrun_sticky: got %b expected 1", Underrun);
        end
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        vectors++;
        if ({Busy, Underrun} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL underrun_after_abort: got Busy,Underrun=%b%b expected 01", Busy, Underrun);
        end
        kick(1, 1);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if ({Busy, Underrun} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL underrun_cleared: got Busy,Underrun=%b%b expected 10", Busy, Underrun);
        end
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
    endtask

    task automatic test_abort;
        int r;
        r = 0;
        kick(3, 0);
        advance_reads(39, r, "abort_lead");
        @(posedge clk); #1;
        abort = 1'b1;
        @(negedge clk);
        vectors++;
        if ({FIFO_rd, Busy} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL abort_40th_read: got FIFO_rd,Busy=%b%b expected 11", FIFO_rd, Busy);
        end
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        vectors++;
        if ({Busy, Done, PatGen_rst, FIFO_rd, Subc_phase} !== 6'b001000) begin
            miscompares++;
            $display("[TB] FAIL abort_idle: got %b expected 001000", {Busy, Done, PatGen_rst, FIFO_rd, Subc_phase});
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            vectors++;
            if (Done !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL abort_no_done: got %b expected 0", Done);
            end
        end
        run_scenario(1, 1, -1, 0, "abort_restart");
    endtask

    task automatic test_reset_midrun;
        int r;
        r = 0;
        kick(3, 1);
        advance_reads(20, r, "midrun_lead");
        vectors++;
        if (CntSubc !== 32'd1) begin
            miscompares++;
            $display("[TB] FAIL midrun_pre_cntsubc: got %0d expected 1", CntSubc);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors += 2;
        if ({PatGen_rst, FIFO_rd, Pat_valid, Busy, Done, Underrun, Subc_phase} !== 8'b10000000) begin
            miscompares++;
            $display("[TB] FAIL midrun_reset_flags: got %b expected 10000000", {PatGen_rst, FIFO_rd, Pat_valid, Busy, Done, Underrun, Subc_phase});
        end
        if ({CntSubc, Frame_cnt} !== 48'd0) begin
            miscompares++;
            $display("[TB] FAIL midrun_reset_counts: got %0d/%0d expected 0/0", CntSubc, Frame_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({Busy, FIFO_rd, PatGen_rst} !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL midrun_after_release: got %b expected 001", {Busy, FIFO_rd, PatGen_rst});
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset;
        test_full_run;
        test_num_pat_zero;
        test_stall;
        test_underrun;
        test_abort;
        test_reset_midrun;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/subc_sequencer.md
# subc_sequencer

Frame-level scheduler for the imager mask path. It holds the pattern generator parked in reset until the host starts a run. It then drains the pattern FIFO into the imager row interface and counts words, subscenes and frames. It publishes `CntSubc`, which the pattern generator uses to decide exposed-pattern continuation and inversion. It sits between the host registers, the pattern-generator/FIFO pair and the imager row driver.

## Interface
Parameters:
- `C_NUM_ROWS`, 160: pixel rows per subscene.
- `C_WORDS_PER_ROW`, 18: 10-bit pattern words per row.
- `C_WORDS_PER_SUBC`, `C_NUM_ROWS*C_WORDS_PER_ROW` (2880): FIFO words per subscene.
- `C_RST_CYCLES`, 2: cycles `PatGen_rst` is held after `start`, before reads begin.

Ports (one clock; reset is asynchronous, active-high):
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `start`  in  1  one-cycle pulse; begins a run from IDLE.
- `abort`  in  1  one-cycle pulse; ends any run immediately.
- `Num_Pat`  in  32  exposed subscenes per frame; 0 is treated as 1.
- `Num_Frames`  in  16  frames per run; 0 means run until `abort`.
- `FIFO_empty`  in  1  pattern FIFO empty flag.
- `Row_ready`  in  1  imager row driver can accept a word this cycle.
- `FIFO_rd`  out  1  FIFO read strobe; combinational.
- `Pat_valid`  out  1  FIFO data valid this cycle (1-cycle read latency).
- `PatGen_rst`  out  1  reset to the pattern generator; registered.
- `CntSubc`  out  32  exposed subscenes completed in the current frame.
- `Frame_cnt`  out  16  frames completed in the current run.
- `Subc_phase`  out  2  0 = idle, 1 = first (blank), 2 = exposed patterns, 3 = last (blank).
- `Busy`  out  1  high in any state other than IDLE.
- `Done`  out  1  one-cycle pulse when a run completes normally.
- `Underrun`  out  1  sticky mid-subscene FIFO starvation flag.

## Operation
- States: S_IDLE, S_RST, S_FIRST, S_PATS, S_LAST, S_DONE. One-hot encoding; illegal states go to S_IDLE.
- S_IDLE: `PatGen_rst`=1. On `start` (and no `abort`): clear `Frame_cnt`, `CntSubc` and `Underrun`, then go to S_RST.
- S_RST: `PatGen_rst`=1 for `C_RST_CYCLES` cycles, then go to S_FIRST with `PatGen_rst`=0.
- Read rule: `FIFO_rd` = `Row_ready` & ~`FIFO_empty` & (state ∈ {S_FIRST, S_PATS, S_LAST}).
- `word_cnt` increments on each `FIFO_rd`. A subscene ends on a `FIFO_rd` with `word_cnt`==`C_WORDS_PER_SUBC`-1; `word_cnt` then wraps to 0.
- S_FIRST subscene end: go to S_PATS.
- S_PATS subscene end: `CntSubc`+1. If the new value equals max(`Num_Pat`,1), go to S_LAST.
- S_LAST subscene end: `Frame_cnt`+1.
  - If `Num_Frames`≠0 and the new value equals `Num_Frames`, go to S_DONE.
  - Otherwise clear `CntSubc` and go to S_FIRST.
- S_DONE: `Done`=1 for one cycle, then go to S_IDLE.
- `abort` in any non-IDLE state: go to S_IDLE next cycle. `word_cnt` is cleared, `Done` is not pulsed, and the counters keep their values.
- `abort` and `start` in the same cycle: `abort` wins.
- `start` outside S_IDLE is ignored.
- `Underrun` sets when `Row_ready` & `FIFO_empty` & `word_cnt`≠0 in S_PATS. It holds until the next accepted `start` or reset.
- `Num_Pat` and `Num_Frames` are sampled continuously. The host must hold them stable while `Busy`=1.

## Timing
- Reset values: state S_IDLE, `PatGen_rst`=1, `FIFO_rd`=0, `Pat_valid`=0, `CntSubc`=0, `Frame_cnt`=0, `Subc_phase`=0, `Busy`=0, `Done`=0, `Underrun`=0.
- `start` at cycle t: `Busy`=1 at t+1. `PatGen_rst` falls at t+1+`C_RST_CYCLES`; the first `FIFO_rd` can occur in that cycle.
- `Pat_valid` is `FIFO_rd` delayed one cycle and is forced to 0 by reset.
- Counter updates, state changes and `Subc_phase` all take effect the cycle after the terminal `FIFO_rd`.
- `Done` is high in the cycle after the last word of the last subscene is read. `Busy` falls in the cycle after that.
- Throughput is one word per cycle while `Row_ready` is high and the FIFO is non-empty. There is no bubble at subscene boundaries.

## Structure
- Shared package `imager_pkg`: state encodings, `C_NUM_ROWS`, `C_WORDS_PER_ROW`, and the `Subc_phase` codes (also used by the pattern generator and row driver).
- One sub-module, `subc_word_counter`: a `C_WORDS_PER_SUBC` modulo counter with enable, synchronous clear and terminal-count output.

## Test plan
Use `C_WORDS_PER_SUBC`=8 in the bench, with the FIFO model always non-empty unless stated.
- Reset mid-run: assert `rst` in S_PATS → all outputs at reset values within the same cycle; `PatGen_rst`=1.
- `Num_Pat`=3, `Num_Frames`=2, `Row_ready`=1 → 2×5×8=80 `FIFO_rd` pulses; `CntSubc` reads 1, 2, 3 then clears; `Done` one cycle after the 80th read; `Frame_cnt`=2.
- `Num_Pat`=0, `Num_Frames`=1 → behaves as `Num_Pat`=1: 24 reads, `CntSubc` ends at 1, `Done` pulses.
- Stall: drop `Row_ready` for 5 cycles mid-subscene → no `FIFO_rd` and no counter change during the stall; totals are unchanged.
- Force `FIFO_empty` after word 3 of an exposed subscene with `Row_ready`=1 → `Underrun`=1 and stays high; the next `start` clears it.
- `abort` together with the 40th read, `Num_Frames`=0 → S_IDLE next cycle; no `Done`; `PatGen_rst`=1; a following `start` restarts from `Frame_cnt`=0.
